// File: rtl/encoder_scan_sched.sv
// encoder_scan_sched: one shared quadrature decode/update datapath.
// On every sample tick it visits each encoder channel in turn (SAMPLE,
// DECODE, UPDATE) and keeps a wrapping position counter and a sticky
// invalid-transition flag per channel. A host port reads and clears them.
module encoder_scan_sched #(
    parameter int NUM_ENC    = 4,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 8,
    parameter int SAMPLE_DIV = 500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_ENC-1:0] enc_a,
    input  logic [NUM_ENC-1:0] enc_b,
    input  logic               rd_req,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic               rd_ack,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_err,
    input  logic               clr_req,
    input  logic [SEL_W-1:0]   clr_sel,
    output logic               busy,
    output logic [CNT_W-1:0]   leds
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, DECODE, UPDATE} state_t;
    typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t;

    logic [NUM_ENC-1:0] a_meta_reg, a_sync_reg, b_meta_reg, b_sync_reg;
    logic [DIV_W-1:0]   div_reg;
    logic               tick;

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   idx_reg, idx_next;
    logic               busy_reg, busy_next;
    logic               prime_reg, prime_next;
    logic               last_ch;

    logic [1:0]         cur_reg;
    step_t              step_reg, step_dec;
    logic [1:0]         prev_sel, diff;

    logic [CNT_W-1:0]   cnt_all [NUM_ENC];
    logic               err_all [NUM_ENC];
    logic [1:0]         prev_all [NUM_ENC];

    logic               rd_ack_reg, rd_err_reg, rd_mux_err;
    logic [CNT_W-1:0]   rd_data_reg, rd_mux_data;

    // Two-flop synchronizers for the asynchronous encoder pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta_reg <= '0;
            a_sync_reg <= '0;
            b_meta_reg <= '0;
            b_sync_reg <= '0;
        end else begin
            a_meta_reg <= enc_a;
            a_sync_reg <= a_meta_reg;
            b_meta_reg <= enc_b;
            b_sync_reg <= b_meta_reg;
        end
    end

    assign tick = (div_reg == DIV_W'(SAMPLE_DIV - 1));

    // Free-running sample divider, tick on its terminal count.
    always_ff @(posedge clk) begin
        if (rst || tick) div_reg <= '0;
        else             div_reg <= div_reg + 1'b1;
    end

    assign last_ch = (idx_reg == SEL_W'(NUM_ENC - 1));

    // Scan FSM state and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            prime_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            busy_reg  <= busy_next;
            prime_reg <= prime_next;
        end
    end

    // Next-state logic; a tick outside IDLE is simply ignored.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        busy_next  = busy_reg;
        prime_next = prime_reg;
        case (state_reg)
            IDLE: begin
                idx_next  = '0;
                busy_next = 1'b0;
                if (tick) begin
                    state_next = SAMPLE;
                    busy_next  = 1'b1;
                end
            end
            SAMPLE: state_next = DECODE;
            DECODE: state_next = UPDATE;
            UPDATE: begin
                if (last_ch) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    prime_next = 1'b0;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = SAMPLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign prev_sel = prev_all[idx_reg];
    assign diff     = cur_reg ^ prev_sel;

    // Gray-step decode: one bit changed gives a direction, both is invalid.
    always_comb begin
        step_dec = STEP_NONE;
        if (diff == 2'b11)
            step_dec = STEP_ERR;
        else if (diff != 2'b00)
            step_dec = (cur_reg[1] ^ prev_sel[0]) ? STEP_INC : STEP_DEC;
    end

    // Shared datapath registers: captured A/B pair and decoded step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_reg  <= 2'b00;
            step_reg <= STEP_NONE;
        end else begin
            if (state_reg == SAMPLE) cur_reg  <= {a_sync_reg[idx_reg], b_sync_reg[idx_reg]};
            if (state_reg == DECODE) step_reg <= step_dec;
        end
    end

    // Per-channel counter, sticky error and previous state.
    for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_reg;
        logic             err_reg;
        logic [1:0]       prev_reg;
        logic             upd_hit, clr_hit;

        assign upd_hit = (state_reg == UPDATE) && (idx_reg == SEL_W'(gi));
        assign clr_hit = clr_req && (clr_sel == SEL_W'(gi));

        // Clear is applied last so it overrides a same-cycle step.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg  <= '0;
                err_reg  <= 1'b0;
                prev_reg <= 2'b00;
            end else begin
                if (upd_hit) begin
                    prev_reg <= cur_reg;
                    if (!prime_reg) begin
                        case (step_reg)
                            STEP_INC: cnt_reg <= cnt_reg + 1'b1;
                            STEP_DEC: cnt_reg <= cnt_reg - 1'b1;
                            STEP_ERR: err_reg <= 1'b1;
                            default:  ;
                        endcase
                    end
                end
                if (clr_hit) begin
                    cnt_reg <= '0;
                    err_reg <= 1'b0;
                end
            end
        end

        assign cnt_all[gi]  = cnt_reg;
        assign err_all[gi]  = err_reg;
        assign prev_all[gi] = prev_reg;
    end

    // Read mux; unused select codes read as zero.
    always_comb begin
        rd_mux_data = '0;
        rd_mux_err  = 1'b0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux_data = cnt_all[i];
                rd_mux_err  = err_all[i];
            end
        end
    end

    // Read response registered from the request cycle (pre-update value).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack_reg  <= 1'b0;
            rd_data_reg <= '0;
            rd_err_reg  <= 1'b0;
        end else begin
            rd_ack_reg <= rd_req;
            if (rd_req) begin
                rd_data_reg <= rd_mux_data;
                rd_err_reg  <= rd_mux_err;
            end
        end
    end

    assign rd_ack  = rd_ack_reg;
    assign rd_data = rd_data_reg;
    assign rd_err  = rd_err_reg;
    assign busy    = busy_reg;
    assign leds    = cnt_all[0];

endmodule

// File: tb/tb_encoder_scan_sched.sv
// Bench for encoder_scan_sched: read expectations go into a scoreboard
// queue when a request is driven and are compared when rd_ack appears.
module tb_encoder_scan_sched;

    localparam int NUM_ENC    = 4;
    localparam int SEL_W      = 2;
    localparam int CNT_W      = 8;
    localparam int SAMPLE_DIV = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_ENC-1:0] enc_a, enc_b;
    logic               rd_req;
    logic [SEL_W-1:0]   rd_sel;
    logic               rd_ack;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_err;
    logic               clr_req;
    logic [SEL_W-1:0]   clr_sel;
    logic               busy;
    logic [CNT_W-1:0]   leds;

    encoder_scan_sched #(
        .NUM_ENC(NUM_ENC), .SEL_W(SEL_W), .CNT_W(CNT_W), .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data),
        .rd_err(rd_err), .clr_req(clr_req), .clr_sel(clr_sel),
        .busy(busy), .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             ch;
        logic [CNT_W-1:0] data;
        logic           err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [CNT_W-1:0]   m_cnt  [NUM_ENC];
    logic               m_err  [NUM_ENC];
    logic [1:0]         m_prev [NUM_ENC];
    logic               m_prime;
    logic [NUM_ENC-1:0] a_v, b_v;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Position of an {A,B} pair along the forward cycle 00,10,11,01.
    function automatic int pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_ENC; c++) begin
            m_cnt[c] = '0; m_err[c] = 1'b0; m_prev[c] = 2'b00;
        end
        m_prime = 1'b1;
    endtask

    task automatic model_scan();
        for (int c = 0; c < NUM_ENC; c++) begin
            logic [1:0] cur;
            int d;
            cur = {enc_a[c], enc_b[c]};
            if (!m_prime) begin
                d = (pos(cur) - pos(m_prev[c]) + 4) % 4;
                if (d == 1)      m_cnt[c] = m_cnt[c] + 8'd1;
                else if (d == 3) m_cnt[c] = m_cnt[c] - 8'd1;
                else if (d == 2) m_err[c] = 1'b1;
            end
            m_prev[c] = cur;
        end
        m_prime = 1'b0;
    endtask

    // Scoreboard side: compare every ack against the oldest expectation.
    always @(negedge clk) begin
        if (rd_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("rd_ack_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val($sformatf("rd_data ch%0d", e.ch), rd_data, e.data);
                check_val($sformatf("rd_err ch%0d", e.ch), rd_err, e.err);
            end
        end
    end

    task automatic wait_busy(input logic lvl, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check_val(tag, busy, lvl);
    endtask

    task automatic issue_read(input int ch);
        exp_t e;
        e.ch = ch; e.data = m_cnt[ch]; e.err = m_err[ch];
        exp_q.push_back(e);
        rd_sel = SEL_W'(ch);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check_val($sformatf("rd_ack ch%0d", ch), rd_ack, 1'b1);
    endtask

    task automatic set_ch(input int ch, input logic [1:0] ab);
        a_v[ch] = ab[1];
        b_v[ch] = ab[0];
    endtask

    // Follow one scan to its end. inject: 1 = clear ch0 in its UPDATE cycle,
    // 2 = read ch0 in its UPDATE cycle, 3 = reset while channel 2 is active.
    task automatic wait_scan(input int inject);
        if (busy !== 1'b1) wait_busy(1'b1, "timeout scan_start");
        if (inject == 1) begin
            repeat (2) @(negedge clk);
            clr_sel = '0; clr_req = 1'b1;
            @(negedge clk);
            clr_req = 1'b0;
        end else if (inject == 2) begin
            repeat (2) @(negedge clk);
            issue_read(0);
        end else if (inject == 3) begin
            repeat (6) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_val("busy after midscan rst", busy, 1'b0);
            check_val("leds after midscan rst", leds, 8'd0);
            model_reset();
            return;
        end
        wait_busy(1'b0, "timeout scan_end");
        model_scan();
        if (inject == 1) begin
            m_cnt[0] = '0;
            m_err[0] = 1'b0;
        end
    endtask

    // Let the current/next scan finish, apply new pin levels, run one scan.
    task automatic do_tick(input int inject);
        wait_scan(0);
        enc_a = a_v;
        enc_b = b_v;
        wait_scan(inject);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] fwd [4];
        logic [1:0] rev [4];
        fwd[0] = 2'b10; fwd[1] = 2'b11; fwd[2] = 2'b01; fwd[3] = 2'b00;
        rev[0] = 2'b01; rev[1] = 2'b11; rev[2] = 2'b10; rev[3] = 2'b00;

        rst = 1'b1; enc_a = '0; enc_b = '0; a_v = '0; b_v = '0;
        rd_req = 1'b0; rd_sel = '0; clr_req = 1'b0; clr_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Move channel 0 before its first (priming) sample.
        set_ch(0, 2'b10);
        enc_a = a_v; enc_b = b_v;

        // 1. Reset state and scan timing
        check_val("busy after reset", busy, 1'b0);
        check_val("leds after reset", leds, 8'd0);
        check_val("rd_ack after reset", rd_ack, 1'b0);
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("busy rise delay", n, 16);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("busy length", n, 12);
        model_scan();
        for (int c = 0; c < NUM_ENC; c++) issue_read(c);
        check_val("leds after prime", leds, m_cnt[0]);

        // 2. Forward then reverse on channel 1
        for (int i = 0; i < 4; i++) begin
            set_ch(1, fwd[i]);
            do_tick(0);
            issue_read(1);
        end
        for (int i = 0; i < 4; i++) begin
            set_ch(1, rev[i]);
            do_tick(0);
            issue_read(1);
        end
        issue_read(0);
        issue_read(2);

        // 3. Wrap-around on channel 2
        set_ch(2, 2'b01);
        do_tick(0);
        issue_read(2);
        set_ch(2, 2'b00);
        do_tick(0);
        issue_read(2);

        // 4. Invalid transition and sticky error on channel 3
        set_ch(3, 2'b11);
        do_tick(0);
        issue_read(3);
        set_ch(3, 2'b01);
        do_tick(0);
        issue_read(3);
        set_ch(3, 2'b00);
        do_tick(0);
        issue_read(3);
        clr_sel = 2'd3; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        m_cnt[3] = '0; m_err[3] = 1'b0;
        issue_read(3);

        // 5. Clear and read colliding with channel 0 UPDATE
        set_ch(0, 2'b11);
        do_tick(1);
        issue_read(0);
        set_ch(0, 2'b01);
        do_tick(2);
        issue_read(0);
        check_val("leds ch0", leds, m_cnt[0]);
        // Held request acks every cycle
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.ch = 0; e.data = m_cnt[0]; e.err = m_err[0];
            exp_q.push_back(e);
        end
        rd_sel = '0; rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val($sformatf("held rd_ack %0d", k), rd_ack, 1'b1);
        end
        rd_req = 1'b0;

        // 6. Reset in the middle of a scan
        set_ch(0, 2'b00);
        set_ch(2, 2'b01);
        do_tick(0);
        issue_read(0);
        issue_read(2);
        set_ch(0, 2'b11);
        do_tick(3);
        wait_scan(0);
        for (int c = 0; c < NUM_ENC; c++) issue_read(c);
        set_ch(0, 2'b01);
        do_tick(0);
        issue_read(0);
        check_val("leds final", leds, m_cnt[0]);

        repeat (3) @(negedge clk);
        check_val("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
